// File: rtl/ctrl_types_pkg.sv
// Shared types for the cache controller: sub-FSM status bundle, opcodes and response codes.
// Pure type/constant package; no logic, no latency, no flow control.
package ctrl_types_pkg;

    typedef struct packed {
        logic done;
        logic error;
    } sub_cmd_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_GET = 2'b01;
    localparam logic [1:0] OP_PUT = 2'b10;
    localparam logic [1:0] OP_DEL = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERROR   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/cache_ctrl_if.sv
// Host request/response handshake bundle for the cache controller.
// Valid/ready on both directions; the master is the host, the slave is the controller.
interface cache_ctrl_if;

    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic       resp_valid;
    logic       resp_ready;
    logic [1:0] resp_status;

    modport master (
        output req_valid, req_op, resp_ready,
        input  req_ready, resp_valid, resp_status
    );

    modport slave (
        input  req_valid, req_op, resp_ready,
        output req_ready, resp_valid, resp_status
    );

endinterface

// File: rtl/cache_ctrl_fsm.sv
// IDLE/EXEC/RESP controller dispatching GET/PUT/DEL to sub-FSMs; min 3 cycles accept-to-response.
// One request in flight; req_ready only in IDLE, RESP holds until resp_ready.
module cache_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cache_ctrl_if.slave               bus,
    output logic                      get_en,
    output logic                      put_en,
    output logic                      del_en,
    output logic                      get_enter,
    output logic                      put_enter,
    output logic                      del_enter,
    input  ctrl_types_pkg::sub_cmd_t  get_cmd,
    input  ctrl_types_pkg::sub_cmd_t  put_cmd,
    input  ctrl_types_pkg::sub_cmd_t  del_cmd,
    output logic                      busy
);

    import ctrl_types_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] op_q;
    logic [7:0] cnt_q;
    logic [1:0] status_q, status_d;
    sub_cmd_t   sel_cmd;
    logic       first_exec;

    // counter is cleared on accept, so zero marks the enter cycle
    assign first_exec = (cnt_q == 8'd0);

    always_comb begin
        sel_cmd = '0;
        case (op_q)
            OP_GET:  sel_cmd = get_cmd;
            OP_PUT:  sel_cmd = put_cmd;
            OP_DEL:  sel_cmd = del_cmd;
            default: sel_cmd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            cnt_q    <= 8'd0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (state_q == S_IDLE && bus.req_valid) begin
                op_q  <= bus.req_op;
                cnt_q <= 8'd0;
            end else if (state_q == S_EXEC && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_op == OP_NOP) begin
                        state_d  = S_RESP;
                        status_d = ST_OK;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                // stale done/error from the previous op is still visible in the enter cycle
                if (!first_exec) begin
                    if (sel_cmd.error) begin
                        state_d  = S_RESP;
                        status_d = ST_ERROR;
                    end else if (sel_cmd.done) begin
                        state_d  = S_RESP;
                        status_d = ST_OK;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d  = S_RESP;
                        status_d = ST_TIMEOUT;
                    end
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_status = status_q;
        busy            = 1'b0;
        get_en          = 1'b0;
        put_en          = 1'b0;
        del_en          = 1'b0;
        get_enter       = 1'b0;
        put_enter       = 1'b0;
        del_enter       = 1'b0;
        case (state_q)
            S_IDLE: bus.req_ready = 1'b1;
            S_EXEC: begin
                busy = 1'b1;
                case (op_q)
                    OP_GET: begin
                        get_en    = 1'b1;
                        get_enter = first_exec;
                    end
                    OP_PUT: begin
                        put_en    = 1'b1;
                        put_enter = first_exec;
                    end
                    OP_DEL: begin
                        del_en    = 1'b1;
                        del_enter = first_exec;
                    end
                    default: ;
                endcase
            end
            S_RESP: begin
                busy           = 1'b1;
                bus.resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: vector table, hand-written corner sequences, randomized transactions
// checked against a per-transaction outcome model.
module tb_cache_ctrl_fsm;

    import ctrl_types_pkg::*;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_ctrl_if bus();

    logic     get_en, put_en, del_en;
    logic     get_enter, put_enter, del_enter;
    sub_cmd_t get_cmd, put_cmd, del_cmd;
    logic     busy;

    cache_ctrl_fsm #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .get_en    (get_en),
        .put_en    (put_en),
        .del_en    (del_en),
        .get_enter (get_enter),
        .put_enter (put_enter),
        .del_enter (del_enter),
        .get_cmd   (get_cmd),
        .put_cmd   (put_cmd),
        .del_cmd   (del_cmd),
        .busy      (busy)
    );

    wire [2:0] en_vec    = {get_en, put_en, del_en};
    wire [2:0] enter_vec = {get_enter, put_enter, del_enter};

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] op;
        int         from;
        int         len;
        logic       done;
        logic       err;
        logic [1:0] exp_st;
        int         exp_n;
        string      name;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(logic [1:0] op, int from, int len, logic d, logic e,
                                logic [1:0] st, int n, string name);
        vec_t v;
        v.op = op; v.from = from; v.len = len; v.done = d; v.err = e;
        v.exp_st = st; v.exp_n = n; v.name = name;
        return v;
    endfunction

    function automatic logic [2:0] sel_of(logic [1:0] op);
        case (op)
            OP_GET:  return 3'b100;
            OP_PUT:  return 3'b010;
            OP_DEL:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic d, input logic e, input bit junk);
        get_cmd = junk ? sub_cmd_t'(2'($urandom_range(0, 3))) : '0;
        put_cmd = junk ? sub_cmd_t'(2'($urandom_range(0, 3))) : '0;
        del_cmd = junk ? sub_cmd_t'(2'($urandom_range(0, 3))) : '0;
        case (op)
            OP_GET: begin get_cmd.done = d; get_cmd.error = e; end
            OP_PUT: begin put_cmd.done = d; put_cmd.error = e; end
            OP_DEL: begin del_cmd.done = d; del_cmd.error = e; end
            default: ;
        endcase
    endtask

    task automatic run_tbl(input vec_t v);
        int         n;
        bit         hit;
        logic [2:0] sel;
        sel = sel_of(v.op);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_op     = v.op;
        chk({v.name, "_req_ready"}, bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 300) begin
            n++;
            chk({v.name, "_en_enter"}, {en_vec, enter_vec}, {sel, (n == 1) ? sel : 3'b000});
            hit = (v.from != 0) && (n >= v.from) && (v.len == 0 || n < v.from + v.len);
            drive_cmd(v.op, hit & v.done, hit & v.err, 1'b0);
            step();
        end
        drive_cmd(OP_NOP, 1'b0, 1'b0, 1'b0);
        chk({v.name, "_exec_cycles"}, n, v.exp_n);
        chk({v.name, "_status"}, bus.resp_status, v.exp_st);
        step();
        chk({v.name, "_back_idle"}, {bus.resp_valid, busy, bus.req_ready}, 3'b001);
    endtask

    task automatic run_random(input int n_txn);
        logic [1:0] op, exp_st;
        logic [2:0] sel;
        int         gap, stalls, exp_n, n;
        bit         cd[T+1];
        bit         ce[T+1];
        for (int t = 0; t < n_txn; t++) begin
            op     = 2'($urandom_range(0, 3));
            gap    = $urandom_range(0, 2);
            stalls = $urandom_range(0, 4);
            for (int k = 1; k <= T; k++) begin
                cd[k] = ($urandom_range(0, 9) == 0);
                ce[k] = ($urandom_range(0, 19) == 0);
            end
            // outcome: first error/done from the second EXEC cycle on, else timeout at cycle T
            if (op == OP_NOP) begin
                exp_n = 0; exp_st = ST_OK;
            end else begin
                exp_n = T; exp_st = ST_TIMEOUT;
                for (int k = T; k >= 2; k--) begin
                    if (ce[k]) begin exp_n = k; exp_st = ST_ERROR; end
                    else if (cd[k]) begin exp_n = k; exp_st = ST_OK; end
                end
            end
            sel = sel_of(op);

            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b0;
            for (int g = 0; g < gap; g++) begin
                drive_cmd(OP_NOP, 1'b0, 1'b0, 1'b1);
                step();
                chk("rnd_idle", {busy, bus.req_ready}, 2'b01);
            end
            bus.req_valid = 1'b1;
            bus.req_op    = op;
            step();
            n = 0;
            while (bus.resp_valid !== 1'b1 && n < 300) begin
                n++;
                chk("rnd_en_enter", {en_vec, enter_vec}, {sel, (n == 1) ? sel : 3'b000});
                drive_cmd(op, (n <= T) ? cd[n] : 1'b0, (n <= T) ? ce[n] : 1'b0, 1'b1);
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_op    = 2'($urandom_range(0, 3));
                step();
            end
            chk("rnd_exec_cycles", n, exp_n);
            chk("rnd_status", bus.resp_status, exp_st);
            for (int s = 0; s < stalls; s++) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                step();
                chk("rnd_hold", {bus.resp_valid, bus.resp_status, bus.req_ready}, {1'b1, exp_st, 1'b0});
            end
            bus.resp_ready = 1'b1;
            bus.req_valid  = 1'($urandom_range(0, 1));
            step();
            chk("rnd_consumed", {bus.resp_valid, busy, bus.req_ready}, 3'b001);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = mk(OP_GET, 2,  0, 1'b1, 1'b0, ST_OK,      2,  "get_done");
        tbl[1] = mk(OP_GET, 2,  0, 1'b0, 1'b1, ST_ERROR,   2,  "get_error");
        tbl[2] = mk(OP_PUT, 0,  0, 1'b0, 1'b0, ST_TIMEOUT, 16, "put_timeout");
        tbl[3] = mk(OP_DEL, 2,  0, 1'b1, 1'b1, ST_ERROR,   2,  "del_done_and_error");
        tbl[4] = mk(OP_PUT, 1,  0, 1'b1, 1'b0, ST_OK,      2,  "put_done_from_first");
        tbl[5] = mk(OP_GET, 1,  1, 1'b1, 1'b0, ST_TIMEOUT, 16, "get_done_first_only");
        tbl[6] = mk(OP_DEL, 16, 0, 1'b1, 1'b0, ST_OK,      16, "del_done_at_timeout");
        tbl[7] = mk(OP_PUT, 16, 0, 1'b0, 1'b1, ST_ERROR,   16, "put_error_at_timeout");
        tbl[8] = mk(OP_GET, 5,  0, 1'b1, 1'b0, ST_OK,      5,  "get_done_late");
        tbl[9] = mk(OP_NOP, 0,  0, 1'b0, 1'b0, ST_OK,      0,  "nop");

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = OP_NOP;
        bus.resp_ready = 1'b1;
        drive_cmd(OP_NOP, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset_outputs",
            {bus.req_ready, bus.resp_valid, busy, en_vec, enter_vec, bus.resp_status},
            {1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;

        // DEL accepted on the first edge after reset, done in cycle 2
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DEL;
        step();
        bus.req_valid = 1'b0;
        chk("del_c1_en_enter_busy", {del_en, del_enter, busy}, 3'b111);
        step();
        chk("del_c2_en_enter", {del_en, del_enter}, 2'b10);
        drive_cmd(OP_DEL, 1'b1, 1'b0, 1'b0);
        step();
        drive_cmd(OP_NOP, 1'b0, 1'b0, 1'b0);
        chk("del_c3_resp", {bus.resp_valid, bus.resp_status}, 3'b100);
        step();
        chk("del_c4_idle", {bus.resp_valid, busy, bus.req_ready}, 3'b001);

        foreach (tbl[i]) run_tbl(tbl[i]);

        // response backpressure with a pending request
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_GET;
        bus.resp_ready = 1'b0;
        step();
        bus.req_op = OP_PUT;
        step();
        drive_cmd(OP_GET, 1'b1, 1'b0, 1'b0);
        step();
        drive_cmd(OP_NOP, 1'b0, 1'b0, 1'b0);
        chk("bp_resp", {bus.resp_valid, bus.resp_status}, 3'b100);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", {bus.resp_valid, bus.resp_status, bus.req_ready, en_vec}, {1'b1, 2'b00, 1'b0, 3'b000});
        end
        bus.resp_ready = 1'b1;
        step();
        chk("bp_consumed", {bus.resp_valid, busy, bus.req_ready}, 3'b001);
        bus.req_valid = 1'b0;
        step();
        chk("bp_not_accepted", {bus.resp_valid, busy, bus.req_ready}, 3'b001);

        // reset in the middle of a DEL
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DEL;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("rst_mid_del_active", {del_en, busy}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_del_cleared", {del_en, del_enter, busy, bus.resp_valid, bus.req_ready}, 5'b00001);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("rst_no_response", {bus.resp_valid, busy}, 2'b00);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_NOP;
        step();
        bus.req_valid = 1'b0;
        chk("rst_nop_resp", {bus.resp_valid, bus.resp_status}, 3'b100);
        step();
        chk("rst_nop_idle", {bus.resp_valid, busy, bus.req_ready}, 3'b001);

        run_random(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_fsm.md
CACHE_CTRL_FSM -- requirements
Module: cache_ctrl_fsm

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of EXEC cycles before an operation is aborted (legal range 2..255).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port req_valid, input, 1, host request present.
REQ-005 The module SHALL have port req_ready, output, 1, controller accepts a request.
REQ-006 The module SHALL have port req_op, input, 2, operation code: 00 NOP, 01 GET, 10 PUT, 11 DEL.
REQ-007 The module SHALL have port resp_valid, output, 1, response present.
REQ-008 The module SHALL have port resp_ready, input, 1, host consumes the response.
REQ-009 The module SHALL have port resp_status, output, 2, response code: 00 OK, 01 ERROR, 10 TIMEOUT.
REQ-010 The module SHALL have ports get_en, put_en and del_en, output, 1 each, meaning the sub-FSM is active.
REQ-011 The module SHALL have ports get_enter, put_enter and del_enter, output, 1 each, meaning the first cycle of the sub-FSM operation.
REQ-012 The module SHALL have ports get_cmd, put_cmd and del_cmd, input, ctrl_types_pkg::sub_cmd_t each, carrying the sub-FSM done/error status.
REQ-013 The module SHALL have port busy, output, 1, asserted whenever state is not IDLE.

Function
REQ-014 The state machine SHALL have three states: IDLE, EXEC and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE.
- A request is accepted on a posedge with req_valid && req_ready.
- On acceptance, req_op SHALL be latched into op_q.
REQ-016 Accepting GET, PUT or DEL SHALL transition IDLE->EXEC and clear the cycle counter to 0.
REQ-017 Accepting NOP SHALL transition IDLE->RESP with resp_status OK; no sub-FSM enable is asserted.
REQ-018 In EXEC, only the sub-FSM selected by op_q SHALL have en=1.
- All other en and enter outputs SHALL be 0 in every state.
REQ-019 The selected sub-FSM's enter SHALL be 1 only in the first EXEC cycle; en SHALL be 1 in that cycle as well.
REQ-020 In the first EXEC cycle, the selected cmd.done and cmd.error SHALL be ignored (stale status from the previous operation).
REQ-021 On any later EXEC cycle, if the selected cmd.error=1, the next state SHALL be RESP with status ERROR.
- error takes priority when done and error are both 1.
REQ-022 On any later EXEC cycle, if cmd.done=1 and cmd.error=0, the next state SHALL be RESP with status OK.
REQ-023 The cycle counter SHALL increment once per EXEC cycle and saturate.
- If it reaches TIMEOUT_CYCLES-1 with no done or error, the next state SHALL be RESP with status TIMEOUT.
- A done or error seen on that same cycle SHALL take priority over timeout.
REQ-024 resp_status SHALL be registered on the EXEC->RESP (or IDLE->RESP) transition and held stable while resp_valid=1.
REQ-025 resp_valid SHALL be 1 exactly in RESP.
- RESP->IDLE occurs on a posedge with resp_ready=1.
- With resp_ready=0, RESP is held indefinitely.
REQ-026 req_valid SHALL be ignored outside IDLE; a request is never accepted in the same cycle a response is consumed.
REQ-027 Minimum latency SHALL be as follows.
- Accept at edge N gives EXEC in cycle N+1 (enter cycle).
- done in cycle N+2 gives resp_valid in cycle N+3.
- Back-to-back operations are separated by at least one IDLE cycle.
REQ-028 An illegal or unknown state encoding SHALL return to IDLE on the next edge with all outputs inactive.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force the following, regardless of current state (including mid-EXEC or RESP):
- state=IDLE, op_q=00, counter=0, resp_status=00;
- resp_valid=0, busy=0 and all en/enter=0, so any in-flight operation is abandoned with no response;
- req_ready=1.
REQ-030 After rst_n deasserts, the first request SHALL be acceptable on the first posedge.

Verification
REQ-031 The bench SHALL cover: DEL accepted at cycle 0, del_cmd.done=1 in cycle 2, resp_ready=1 -> del_enter=1 and del_en=1 in cycle 1, resp_valid=1 with status 00 in cycle 3, IDLE in cycle 4.
REQ-032 The bench SHALL cover: GET accepted, get_cmd.error=1 in the second EXEC cycle -> resp_status=01; put_en and del_en remain 0 throughout.
REQ-033 The bench SHALL cover: PUT accepted with TIMEOUT_CYCLES=16 and put_cmd held 0 -> exactly 16 EXEC cycles, then resp_status=10.
REQ-034 The bench SHALL cover: done=1 and error=1 together, and a separate case with done=1 on the first EXEC cycle -> status 01 for the former; the latter's done is ignored and the FSM stays in EXEC.
REQ-035 The bench SHALL cover: resp_ready=0 for 5 cycles while req_valid=1 -> resp_valid and resp_status stable, req_ready=0, no new request accepted.
REQ-036 The bench SHALL cover: rst_n pulsed low mid-EXEC of a DEL -> del_en=0 and busy=0 immediately, no response, and NOP accepted next gives status 00.
